// File: rtl/pe_border_feeder_pkg.sv
// pe_border_feeder_pkg
// Shared definitions for the PE border feeder:
//   - default operand and accumulator widths
//   - the feeder FSM state encoding (IDLE / LOAD / MAC)
//   - mac_window(): length of the unary MAC window for a given operand width
package pe_border_feeder_pkg;

  localparam int DEF_IWIDTH = 8;
  localparam int DEF_OWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2
  } state_t;

  // A unary MAC over a signed IWIDTH-bit activation needs one cycle per
  // magnitude step, so the window is 2^(IWIDTH-1) cycles.
  function automatic int mac_window(input int iwidth);
    return 1 << (iwidth - 1);
  endfunction

endpackage

// File: rtl/pe_border_feeder_sm_convert.sv
// sm_convert
// Combinational two's-complement to sign-magnitude conversion.
// The most negative input has no positive counterpart in IWIDTH-1 bits,
// so its magnitude saturates to all ones.
// Ports:
//   value [IWIDTH-1:0]  in   signed two's-complement operand
//   sign                out  operand MSB
//   mag   [IWIDTH-2:0]  out  absolute value, saturated
module sm_convert
  import pe_border_feeder_pkg::*;
#(
  parameter int IWIDTH = DEF_IWIDTH
) (
  input  logic [IWIDTH-1:0] value,
  output logic              sign,
  output logic [IWIDTH-2:0] mag
);

  logic [IWIDTH-1:0] negated;

  always_comb begin
    negated = -value;
    sign    = value[IWIDTH-1];
    if (!value[IWIDTH-1]) begin
      mag = value[IWIDTH-2:0];
    end else if (value[IWIDTH-2:0] == '0) begin
      // -2^(IWIDTH-1): clamp to the largest representable magnitude
      mag = '1;
    end else begin
      mag = negated[IWIDTH-2:0];
    end
  end

endmodule

// File: rtl/pe_border_feeder.sv
// pe_border_feeder
// Feeds one (activation, weight) pair at a time into a row of unary MAC
// processing elements. Each accepted pair costs one LOAD cycle (PE input and
// weight registers are enabled, the output accumulator is optionally
// cleared) followed by a MAC window during which the PE accumulates.
// A new pair can be accepted in the final MAC cycle, giving back-to-back
// windows with no idle gap.
//
// Optional feature (macro PE_FEEDER_EARLY_TERM_EN): adds cfg_mac_cycles,
// sampled with each pair; the window becomes min(cfg, N), with 0 meaning N.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        operand-pair handshake
//   in_ifm, in_wght            signed activation / signed weight
//   in_first / in_last         pair opens / closes an output accumulation
//   flush                      abort current operation, pulse PE clears
//   cfg_mac_cycles             window length (only with the macro)
//   ifm, wght_sign, wght_abs   registered operands for the PE row
//   en_i, clr_i, en_w, clr_w,
//   en_o, clr_o, mac_done      registered PE control strobes
//   busy                       high outside IDLE
module pe_border_feeder
  import pe_border_feeder_pkg::*;
#(
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int OWIDTH = DEF_OWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_ifm,
  input  logic [IWIDTH-1:0] in_wght,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              flush,
`ifdef PE_FEEDER_EARLY_TERM_EN
  input  logic [IWIDTH-1:0] cfg_mac_cycles,
`endif
  output logic [IWIDTH-1:0] ifm,
  output logic              wght_sign,
  output logic [IWIDTH-2:0] wght_abs,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done,
  output logic              busy
);

  localparam int N  = mac_window(IWIDTH);
  localparam int CW = IWIDTH - 1;

  // Accumulating N products of (IWIDTH-1)-bit magnitudes needs this much room
  if (OWIDTH < 2 * IWIDTH - 1) begin : g_owidth_check
    $error("pe_border_feeder: OWIDTH too narrow for IWIDTH");
  end

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_load;
  logic              last_r;
  logic              take;
  logic              conv_sign;
  logic [IWIDTH-2:0] conv_mag;

  sm_convert #(
    .IWIDTH(IWIDTH)
  ) u_sm_convert (
    .value(in_wght),
    .sign (conv_sign),
    .mag  (conv_mag)
  );

`ifdef PE_FEEDER_EARLY_TERM_EN
  localparam logic [IWIDTH-1:0] N_W = IWIDTH'(N);

  // Counter start value is window-1; 0 or anything beyond N falls back to N
  always_comb begin
    cnt_load = CW'(N - 1);
    if (cfg_mac_cycles != '0 && cfg_mac_cycles < N_W) begin
      cnt_load = cfg_mac_cycles[CW-1:0] - 1'b1;
    end
  end
`else
  assign cnt_load = CW'(N - 1);
`endif

  // Ready in IDLE and in the final MAC cycle (counter exhausted)
  assign in_ready = (state == IDLE) || (state == MAC && cnt == '0);
  assign take     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Single FSM block: strobes are registered for the state being entered,
  // so they line up with the state they describe. clr_o carries in_first
  // into the LOAD cycle, last_r keeps in_last until the window closes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ifm       <= '0;
      wght_sign <= 1'b0;
      wght_abs  <= '0;
      last_r    <= 1'b0;
      en_i      <= 1'b0;
      clr_i     <= 1'b0;
      en_w      <= 1'b0;
      clr_w     <= 1'b0;
      en_o      <= 1'b0;
      clr_o     <= 1'b0;
      mac_done  <= 1'b0;
    end else if (flush) begin
      // Any same-cycle transfer is dropped; the PE gets a one-cycle clear
      state    <= IDLE;
      cnt      <= '0;
      en_i     <= 1'b0;
      en_w     <= 1'b0;
      en_o     <= 1'b0;
      mac_done <= 1'b0;
      clr_i    <= 1'b1;
      clr_w    <= 1'b1;
      clr_o    <= 1'b1;
    end else begin
      en_i     <= 1'b0;
      clr_i    <= 1'b0;
      en_w     <= 1'b0;
      clr_w    <= 1'b0;
      en_o     <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
      if (take) begin
        state     <= LOAD;
        cnt       <= cnt_load;
        ifm       <= in_ifm;
        wght_sign <= conv_sign;
        wght_abs  <= conv_mag;
        last_r    <= in_last;
        en_i      <= 1'b1;
        en_w      <= 1'b1;
        clr_o     <= in_first;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          LOAD: begin
            // A one-cycle window makes the first MAC cycle the final one
            state    <= MAC;
            en_o     <= 1'b1;
            mac_done <= last_r && (cnt == '0);
          end
          MAC: begin
            if (cnt != '0) begin
              cnt      <= cnt - 1'b1;
              en_o     <= 1'b1;
              mac_done <= last_r && (cnt == CW'(1));
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_border_feeder.sv
// tb_pe_border_feeder
// Self-checking bench for pe_border_feeder (IWIDTH=8, N=128).
// A table of single pairs is applied and checked through a scoreboard that
// is popped on every LOAD cycle; MAC windows are measured by a monitor.
// Hand-written sequences cover back-to-back pairs, flush and mid-MAC reset.
// Build with PE_FEEDER_EARLY_TERM_EN defined to also cover cfg_mac_cycles.
`timescale 1ns/1ps
module tb_pe_border_feeder;

  localparam int IW = 8;
  localparam int N  = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_ifm;
  logic [IW-1:0] in_wght;
  logic          in_first;
  logic          in_last;
  logic          flush;
`ifdef PE_FEEDER_EARLY_TERM_EN
  logic [IW-1:0] cfg_mac_cycles;
`endif
  logic [IW-1:0] ifm;
  logic          wght_sign;
  logic [IW-2:0] wght_abs;
  logic          en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, busy;

  pe_border_feeder #(
    .IWIDTH(IW),
    .OWIDTH(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ifm        (in_ifm),
    .in_wght       (in_wght),
    .in_first      (in_first),
    .in_last       (in_last),
    .flush         (flush),
`ifdef PE_FEEDER_EARLY_TERM_EN
    .cfg_mac_cycles(cfg_mac_cycles),
`endif
    .ifm           (ifm),
    .wght_sign     (wght_sign),
    .wght_abs      (wght_abs),
    .en_i          (en_i),
    .clr_i         (clr_i),
    .en_w          (en_w),
    .clr_w         (clr_w),
    .en_o          (en_o),
    .clr_o         (clr_o),
    .mac_done      (mac_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ifm;
    logic [7:0] wght;
    logic       first;
    logic       last;
    logic [7:0] cfg;
    logic       sign;
    logic [6:0] mag;
    int         win;
  } vec_t;

  typedef struct {
    logic [7:0] ifm;
    logic       sign;
    logic [6:0] mag;
    logic       clr_o;
    logic       last;
    int         win;
  } exp_t;

  exp_t sb[$];
  int   load_times[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  logic aborting = 1'b0;
  exp_t cur;
  int   en_cnt   = 0;

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired before DUT responded", name);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_strobes"}, {en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done}, 7'b0);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_ready"}, in_ready, 1'b1);
  endtask

  // Waits for in_ready, drives one pair and records what the LOAD must show.
  // in_valid is left high; callers lower it when no pair follows.
  task automatic apply_stimulus(input vec_t v);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      timeout_fail("ready_wait");
      return;
    end
    in_valid = 1'b1;
    in_ifm   = v.ifm;
    in_wght  = v.wght;
    in_first = v.first;
    in_last  = v.last;
`ifdef PE_FEEDER_EARLY_TERM_EN
    cfg_mac_cycles = v.cfg;
`endif
    sb.push_back('{v.ifm, v.sign, v.mag, v.first, v.last, v.win});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (busy) timeout_fail("idle_wait");
  endtask

  // Monitor: pops the scoreboard on LOAD, measures each en_o window
  always @(negedge clk) begin
    if (en_cnt > 0 && !en_o) begin
      if (!aborting) check_output("mac_len", en_cnt, cur.win);
      aborting = 1'b0;
      en_cnt   = 0;
    end
    if (en_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb_underflow: actual LOAD required no LOAD");
      end else begin
        cur = sb.pop_front();
        load_times.push_back(cycle);
        check_output("load_ifm", ifm, cur.ifm);
        check_output("load_sign", wght_sign, cur.sign);
        check_output("load_abs", wght_abs, cur.mag);
        check_output("load_clr_o", clr_o, cur.clr_o);
        check_output("load_en_w_en_o", {en_w, en_o, mac_done}, 3'b100);
        check_output("load_ready_busy", {in_ready, busy}, 2'b01);
      end
    end
    if (en_o) begin
      en_cnt++;
      check_output("mac_hold", {ifm, wght_sign, wght_abs}, {cur.ifm, cur.sign, cur.mag});
      check_output("mac_done", mac_done, cur.last && (en_cnt == cur.win));
      check_output("mac_ready", in_ready, en_cnt == cur.win);
      check_output("mac_en_i", en_i, 1'b0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    vec_t b2b[4];
    vec_t v;

    tbl[0] = '{8'd5,    8'hFD, 1'b1, 1'b1, 8'd0, 1'b1, 7'd3,   N};
    tbl[1] = '{8'hF9,   8'h80, 1'b1, 1'b1, 8'd0, 1'b1, 7'd127, N};
    tbl[2] = '{8'd127,  8'd127, 1'b1, 1'b1, 8'd0, 1'b0, 7'd127, N};
    tbl[3] = '{8'h80,   8'd0,  1'b1, 1'b1, 8'd0, 1'b0, 7'd0,   N};
    tbl[4] = '{8'd0,    8'hFF, 1'b1, 1'b1, 8'd0, 1'b1, 7'd1,   N};
    tbl[5] = '{8'd33,   8'd64, 1'b0, 1'b0, 8'd0, 1'b0, 7'd64,  N};

    b2b[0] = '{8'd1,  8'h81, 1'b1, 1'b0, 8'd0, 1'b1, 7'd127, N};
    b2b[1] = '{8'd2,  8'd10, 1'b0, 1'b0, 8'd0, 1'b0, 7'd10,  N};
    b2b[2] = '{8'd3,  8'hF6, 1'b0, 1'b0, 8'd0, 1'b1, 7'd10,  N};
    b2b[3] = '{8'd4,  8'd1,  1'b0, 1'b1, 8'd0, 1'b0, 7'd1,   N};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ifm   = '0;
    in_wght  = '0;
    in_first = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
`ifdef PE_FEEDER_EARLY_TERM_EN
    cfg_mac_cycles = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check_idle("reset");
    check_output("reset_data", {ifm, wght_sign, wght_abs}, 16'h0);

    // Single pairs from the table, each run to completion
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i]);
      in_valid = 1'b0;
      wait_idle();
      check_idle("idle_after_vec");
      check_output("sb_drain", sb.size(), 0);
    end

    // Four pairs under continuous in_valid: one LOAD every N+1 cycles
    load_times.delete();
    for (int i = 0; i < 4; i++) apply_stimulus(b2b[i]);
    in_valid = 1'b0;
    wait_idle();
    check_output("b2b_loads", load_times.size(), 4);
    for (int k = 1; k < 4 && k < load_times.size(); k++) begin
      check_output("b2b_period", load_times[k] - load_times[k-1], N + 1);
    end

    // Flush in MAC cycle 40 with a pair offered
    v = '{8'd9, 8'hFE, 1'b1, 1'b1, 8'd0, 1'b1, 7'd2, N};
    apply_stimulus(v);
    in_valid = 1'b0;
    repeat (41) @(negedge clk);
    check_output("pre_flush_en_o", en_o, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ifm   = 8'h55;
    aborting = 1'b1;
    @(negedge clk);
    check_output("flush_clears", {clr_i, clr_w, clr_o}, 3'b111);
    check_output("flush_enables", {en_i, en_w, en_o, mac_done}, 4'b0);
    check_output("flush_busy", busy, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("after_flush");

    // Flush in the final MAC cycle while a transfer is offered: pair dropped
    v = '{8'd7, 8'd3, 1'b1, 1'b0, 8'd0, 1'b0, 7'd3, N};
    apply_stimulus(v);
    in_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) timeout_fail("final_cycle_wait");
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ifm   = 8'h66;
    aborting = 1'b1;
    @(negedge clk);
    check_output("flush_final_busy", busy, 1'b0);
    check_output("flush_final_en_i", en_i, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("after_final_flush");

    // Reset in MAC cycle 10
    v = '{8'd11, 8'hF0, 1'b1, 1'b1, 8'd0, 1'b1, 7'd16, N};
    apply_stimulus(v);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check_output("pre_reset_en_o", en_o, 1'b1);
    rst_n    = 1'b0;
    aborting = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    check_output("mid_reset_data", {ifm, wght_sign, wght_abs}, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_mid_reset");

`ifdef PE_FEEDER_EARLY_TERM_EN
    begin
      vec_t et[4];
      et[0] = '{8'd2, 8'd5, 1'b1, 1'b1, 8'd16,  1'b0, 7'd5, 16};
      et[1] = '{8'd3, 8'd6, 1'b1, 1'b1, 8'd0,   1'b0, 7'd6, N};
      et[2] = '{8'd4, 8'd7, 1'b1, 1'b1, 8'd200, 1'b0, 7'd7, N};
      et[3] = '{8'd5, 8'd8, 1'b1, 1'b1, 8'd1,   1'b0, 7'd8, 1};
      for (int i = 0; i < 4; i++) begin
        apply_stimulus(et[i]);
        in_valid = 1'b0;
        wait_idle();
        check_idle("idle_after_cfg");
      end
    end
`endif

    repeat (2) @(negedge clk);
    check_output("sb_final_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_border_feeder.md
PE_BORDER_FEEDER -- requirements
Module: pe_border_feeder

Interface
REQ-001 Parameter IWIDTH, default 8, operand width in two's complement; sets the unary MAC window N = 2^(IWIDTH-1) cycles.
REQ-002 Parameter OWIDTH, default 16, accumulator width; used only for the package constants.
REQ-003 clk  in  1  single clock; every register updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  operand-pair handshake; a transfer occurs when both are high on a rising edge.
REQ-006 in_ifm, in_wght  in  IWIDTH each  signed activation and signed weight.
REQ-007 in_first / in_last  in  1 / 1  pair opens / closes an output accumulation.
REQ-008 flush  in  1  abort the current operation.
REQ-009 ifm  out  IWIDTH  registered activation for the PE row.
REQ-010 wght_sign / wght_abs  out  1 / IWIDTH-1  registered sign-magnitude weight.
REQ-011 en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done  out  1 each  registered PE control strobes.
REQ-012 busy  out  1  high outside IDLE.

Function
REQ-013 The FSM shall have three states: IDLE, LOAD and MAC.
REQ-014 in_ready shall be high in IDLE and in the final MAC cycle, and low otherwise.
REQ-015 On a transfer, the block shall register ifm, the weight sign/magnitude, first and last, and enter LOAD on the next cycle.
REQ-016 Weight conversion: wght_sign = MSB; wght_abs = |in_wght|; -2^(IWIDTH-1) saturates to 2^(IWIDTH-1)-1.
REQ-017 LOAD shall last 1 cycle with en_i=1, en_w=1, clr_o=first, en_o=0, then enter MAC.
REQ-018 MAC shall last exactly N cycles with en_o=1, counted by an (IWIDTH-1)-bit down-counter loaded with N-1 in LOAD.
REQ-019 mac_done shall be 1 only in the final MAC cycle, and only if last=1.
REQ-020 At the final MAC cycle, a transfer shall go to LOAD with no gap; otherwise the FSM shall go to IDLE.
REQ-021 Throughput shall be one pair per N+1 cycles under continuous in_valid.
REQ-022 ifm, wght_sign and wght_abs shall be stable from LOAD through the final MAC cycle.
REQ-023 flush shall have priority over every state: the next cycle is IDLE, clr_i=clr_w=clr_o=1 for 1 cycle, en_*=0, mac_done=0, and any same-cycle transfer is dropped.
REQ-024 In IDLE, all strobes shall be 0 except the flush clears.

Reset
REQ-025 When rst_n=0 at an edge: state = IDLE, counter = 0, ifm = 0, wght_sign = 0, wght_abs = 0, all strobes = 0, busy = 0, and in_ready = 1 from the first cycle after reset.
REQ-026 Reset in mid-MAC shall abandon the operation without asserting mac_done.

Configuration
REQ-027 Macro PE_FEEDER_EARLY_TERM_EN: when defined, an extra input cfg_mac_cycles [IWIDTH-1:0] is sampled on each transfer; the window is min(cfg, N), and 0 means N.
REQ-028 Macro PE_FEEDER_EARLY_TERM_EN: when undefined, the port is absent and the window is fixed at N.

Structure
REQ-029 The shared package shall hold the FSM state enum (IDLE/LOAD/MAC), the function for N, and the default IWIDTH/OWIDTH constants.
REQ-030 One sub-module, sm_convert, shall hold the combinational two's-complement to sign-magnitude conversion with saturation.

Verification
REQ-031 Reset, then ifm=5, wght=-3, first=1, last=1 -> LOAD shows en_i=en_w=clr_o=1, wght_sign=1, wght_abs=3; en_o=1 for 128 cycles; mac_done on cycle 128 only.
REQ-032 wght=-128 -> wght_sign=1, wght_abs=127.
REQ-033 Four back-to-back pairs (first on 1st, last on 4th) -> period 129 cycles; clr_o only in the 1st LOAD; one mac_done at the end.
REQ-034 flush at MAC cycle 40 with in_valid=1 -> next cycle IDLE with clr_i=clr_w=clr_o=1; no mac_done; the pair is not accepted.
REQ-035 rst_n=0 at MAC cycle 10 -> all outputs 0 on the next cycle; busy=0; no mac_done.
REQ-036 With PE_FEEDER_EARLY_TERM_EN defined: cfg=16 -> 16 en_o cycles; cfg=0 -> 128; cfg=200 -> 128.
